// File: rtl/rcon_seq.sv
// rtl/rcon_seq.sv - AES round-constant stepper (GF(2^8) xtime), start/advance handshake.
// Optional reverse stepping for the decryption key schedule: RCON_REWIND_EN.
module rcon_seq #(
   parameter int         KEY_BITS = 128,
   parameter logic [7:0] POLY     = 8'h1B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       advance,
`ifdef RCON_REWIND_EN
   input  logic       dir,
`endif
   output logic [7:0] rcon,
   output logic       rcon_valid,
   output logic [3:0] round_idx,
   output logic       last,
   output logic       done
);

   localparam logic [3:0] NUM_RCON = (KEY_BITS == 192) ? 4'd8 :
                                     (KEY_BITS == 256) ? 4'd7 : 4'd10;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t     state, state_nx;
   logic [7:0] rcon_nx;
   logic [3:0] idx_nx;
   logic       valid_nx;
   logic       done_nx;
   logic       at_end;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
   endfunction

`ifdef RCON_REWIND_EN
   // Final constant of the forward sequence, i.e. the rewind starting point.
   localparam logic [7:0] RCON_FINAL = (NUM_RCON == 4'd8) ? 8'h80 :
                                       (NUM_RCON == 4'd7) ? 8'h40 : 8'h36;

   logic rev, rev_nx;

   function automatic logic [7:0] inv_xtime(input logic [7:0] v);
      return v[0] ? (((v ^ POLY) >> 1) | 8'h80) : (v >> 1);
   endfunction

   assign at_end = rev ? (round_idx == 4'd1) : (round_idx == NUM_RCON);
`else
   assign at_end = (round_idx == NUM_RCON);
`endif

   assign last = (state == RUN) && at_end;

   always_comb begin
      state_nx = state;
      rcon_nx  = rcon;
      idx_nx   = round_idx;
      valid_nx = rcon_valid;
      done_nx  = 1'b0;
`ifdef RCON_REWIND_EN
      rev_nx   = rev;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               valid_nx = 1'b1;
`ifdef RCON_REWIND_EN
               rev_nx   = dir;
               rcon_nx  = dir ? RCON_FINAL : 8'h01;
               idx_nx   = dir ? NUM_RCON : 4'd1;
`else
               rcon_nx  = 8'h01;
               idx_nx   = 4'd1;
`endif
            end
         end
         RUN: begin
            if (start) begin
`ifdef RCON_REWIND_EN
               rev_nx  = dir;
               rcon_nx = dir ? RCON_FINAL : 8'h01;
               idx_nx  = dir ? NUM_RCON : 4'd1;
`else
               rcon_nx = 8'h01;
               idx_nx  = 4'd1;
`endif
            end else if (advance) begin
               if (at_end) begin
                  state_nx = FIN;
                  rcon_nx  = 8'h00;
                  idx_nx   = 4'd0;
                  valid_nx = 1'b0;
                  done_nx  = 1'b1;
               end else begin
`ifdef RCON_REWIND_EN
                  rcon_nx = rev ? inv_xtime(rcon) : xtime(rcon);
                  idx_nx  = rev ? round_idx - 4'd1 : round_idx + 4'd1;
`else
                  rcon_nx = xtime(rcon);
                  idx_nx  = round_idx + 4'd1;
`endif
               end
            end
         end
         FIN: begin
            // start here is deliberately dropped; it must be re-issued in IDLE.
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            rcon_nx  = 8'h00;
            idx_nx   = 4'd0;
            valid_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rcon       <= 8'h00;
         round_idx  <= 4'd0;
         rcon_valid <= 1'b0;
         done       <= 1'b0;
`ifdef RCON_REWIND_EN
         rev        <= 1'b0;
`endif
      end else begin
         state      <= state_nx;
         rcon       <= rcon_nx;
         round_idx  <= idx_nx;
         rcon_valid <= valid_nx;
         done       <= done_nx;
`ifdef RCON_REWIND_EN
         rev        <= rev_nx;
`endif
      end
   end

endmodule

// File: tb/tb_rcon_seq.sv
// tb/tb_rcon_seq.sv - scoreboard bench for rcon_seq, three key sizes driven in lockstep.
// Rewind steps are included when RCON_REWIND_EN is defined.
module tb_rcon_seq;

   logic clk = 1'b0;
   logic rst_n, start, advance, dir;

   logic [7:0] rcon  [3];
   logic       valid [3];
   logic [3:0] idx   [3];
   logic       last  [3];
   logic       done  [3];

   always #5 clk = ~clk;

`ifdef RCON_REWIND_EN
   rcon_seq #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .start(start), .advance(advance), .dir(dir),
      .rcon(rcon[0]), .rcon_valid(valid[0]), .round_idx(idx[0]), .last(last[0]), .done(done[0]));
   rcon_seq #(.KEY_BITS(192)) dut192 (.clk(clk), .rst_n(rst_n), .start(start), .advance(advance), .dir(dir),
      .rcon(rcon[1]), .rcon_valid(valid[1]), .round_idx(idx[1]), .last(last[1]), .done(done[1]));
   rcon_seq #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .start(start), .advance(advance), .dir(dir),
      .rcon(rcon[2]), .rcon_valid(valid[2]), .round_idx(idx[2]), .last(last[2]), .done(done[2]));
`else
   rcon_seq #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .start(start), .advance(advance),
      .rcon(rcon[0]), .rcon_valid(valid[0]), .round_idx(idx[0]), .last(last[0]), .done(done[0]));
   rcon_seq #(.KEY_BITS(192)) dut192 (.clk(clk), .rst_n(rst_n), .start(start), .advance(advance),
      .rcon(rcon[1]), .rcon_valid(valid[1]), .round_idx(idx[1]), .last(last[1]), .done(done[1]));
   rcon_seq #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .start(start), .advance(advance),
      .rcon(rcon[2]), .rcon_valid(valid[2]), .round_idx(idx[2]), .last(last[2]), .done(done[2]));
`endif

   typedef struct packed {
      logic [7:0] rcon;
      logic       valid;
      logic [3:0] idx;
      logic       last;
      logic       done;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference constants written out directly: 01,02,04,...,1B,36.
   logic [7:0] tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
   int   n_of  [3] = '{10, 8, 7};
   int   m_st  [3];   // 0 idle, 1 run, 2 fin
   int   m_idx [3];
   logic m_rev [3];

   task automatic model_step(input logic r, input logic s, input logic a, input logic d);
      for (int k = 0; k < 3; k++) begin
         if (!r) begin
            m_st[k] = 0; m_idx[k] = 0; m_rev[k] = 1'b0;
         end else if (m_st[k] == 0) begin
            if (s) begin
               m_st[k] = 1; m_rev[k] = d; m_idx[k] = d ? n_of[k] : 1;
            end
         end else if (m_st[k] == 1) begin
            if (s) begin
               m_rev[k] = d; m_idx[k] = d ? n_of[k] : 1;
            end else if (a) begin
               if (m_rev[k] ? (m_idx[k] == 1) : (m_idx[k] == n_of[k])) begin
                  m_st[k] = 2; m_idx[k] = 0;
               end else begin
                  m_idx[k] = m_rev[k] ? m_idx[k] - 1 : m_idx[k] + 1;
               end
            end
         end else begin
            m_st[k] = 0;
         end
      end
   endtask

   function automatic exp_t model_out(input int k);
      exp_t e;
      e.valid = (m_st[k] == 1);
      e.idx   = e.valid ? 4'(m_idx[k]) : 4'd0;
      e.rcon  = e.valid ? tbl[m_idx[k] - 1] : 8'h00;
      e.last  = e.valid && (m_rev[k] ? (m_idx[k] == 1) : (m_idx[k] == n_of[k]));
      e.done  = (m_st[k] == 2);
      return e;
   endfunction

   task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s key%0d observed=%h expected=%h", tag, k, obs, exp);
   endtask

   task automatic cycle(input logic r, input logic s, input logic a, input logic d);
      exp_t e;
      @(negedge clk);
      rst_n = r; start = s; advance = a; dir = d;
      model_step(r, s, a, d);
      for (int k = 0; k < 3; k++) q.push_back(model_out(k));
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         e = q.pop_front();
         check("rcon",       k, rcon[k],         e.rcon);
         check("rcon_valid", k, {7'd0, valid[k]}, {7'd0, e.valid});
         check("round_idx",  k, {4'd0, idx[k]},  {4'd0, e.idx});
         check("last",       k, {7'd0, last[k]}, {7'd0, e.last});
         check("done",       k, {7'd0, done[k]}, {7'd0, e.done});
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; advance = 1'b0; dir = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_idx[k] = 0; m_rev[k] = 1'b0;
      end
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      // advance with no start: nothing moves, no done
      repeat (3) cycle(1, 0, 1, 0);
      // full forward run with gaps; 192/256 finish early and ignore further advances
      cycle(1, 1, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         cycle(1, 0, 1, 0);
         if (i % 3 == 0) cycle(1, 0, 0, 0);
      end
      cycle(1, 0, 1, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      // start beats advance at round 5
      cycle(1, 1, 0, 0);
      repeat (4) cycle(1, 0, 1, 0);
      cycle(1, 1, 1, 0);
      cycle(1, 0, 0, 0);
      // reset at round 7, then advance alone
      repeat (6) cycle(1, 0, 1, 0);
      cycle(0, 0, 0, 0);
      repeat (2) cycle(1, 0, 1, 0);
      // start during FIN is dropped
      cycle(1, 1, 0, 0);
      repeat (10) cycle(1, 0, 1, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 0);
`ifdef RCON_REWIND_EN
      cycle(1, 1, 0, 1);
      for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      // forward again after a rewind
      cycle(1, 1, 0, 0);
      cycle(1, 0, 1, 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
